// File: rtl/serial_compare_ctrl.sv
// Sequencer that time-shares an external 1-bit comparator slice to compare two
// unsigned operands MSB-first, stopping at the first differing bit.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; slice inputs parked at 0
// COMPARE | presenting a_reg[idx]/b_reg[idx] to the slice, idx counts down
// DONE    | one-cycle done pulse, results already registered
module serial_compare_ctrl #(
    parameter  int WIDTH = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             bit_a,
    output logic             bit_b,
    input  logic             slice_lt,
    input  logic             slice_gt,
    input  logic             slice_eq,
    output logic             busy,
    output logic             done,
    output logic             a_lt_b,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_reg, a_reg_nxt;
    logic [WIDTH-1:0]   b_reg, b_reg_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic               lt_nxt, gt_nxt, eq_nxt, err_nxt;
    logic               slice_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            idx    <= '0;
            a_lt_b <= 1'b0;
            a_gt_b <= 1'b0;
            a_eq_b <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            a_reg  <= a_reg_nxt;
            b_reg  <= b_reg_nxt;
            idx    <= idx_nxt;
            a_lt_b <= lt_nxt;
            a_gt_b <= gt_nxt;
            a_eq_b <= eq_nxt;
            err    <= err_nxt;
        end
    end

    // A healthy slice asserts exactly one of its three outputs.
    assign slice_ok = slice_eq ? !(slice_lt || slice_gt) : (slice_lt ^ slice_gt);

    always_comb begin
        state_nxt = state;
        a_reg_nxt = a_reg;
        b_reg_nxt = b_reg;
        idx_nxt   = idx;
        lt_nxt    = a_lt_b;
        gt_nxt    = a_gt_b;
        eq_nxt    = a_eq_b;
        err_nxt   = err;
        busy      = 1'b0;
        done      = 1'b0;
        bit_a     = 1'b0;
        bit_b     = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    a_reg_nxt = a;
                    b_reg_nxt = b;
                    idx_nxt   = IDX_W'(WIDTH - 1);
                    state_nxt = COMPARE;
                end
            end
            COMPARE: begin
                busy  = 1'b1;
                bit_a = a_reg[idx];
                bit_b = b_reg[idx];
                if (!slice_ok) begin
                    lt_nxt    = 1'b0;
                    gt_nxt    = 1'b0;
                    eq_nxt    = 1'b0;
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end else if (slice_eq) begin
                    if (idx == '0) begin
                        lt_nxt    = 1'b0;
                        gt_nxt    = 1'b0;
                        eq_nxt    = 1'b1;
                        err_nxt   = 1'b0;
                        state_nxt = DONE;
                    end else begin
                        idx_nxt = idx - IDX_W'(1);
                    end
                end else begin
                    lt_nxt    = slice_lt;
                    gt_nxt    = slice_gt;
                    eq_nxt    = 1'b0;
                    err_nxt   = 1'b0;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Bench for serial_compare_ctrl: behavioural 1-bit slice with fault injection,
// directed scenarios plus randomized operations against an arithmetic model.
module tb_serial_compare_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             bit_a, bit_b;
    logic             slice_lt, slice_gt, slice_eq;
    logic             busy, done, a_lt_b, a_gt_b, a_eq_b, err;
    logic             fault = 1'b0;
    logic [WIDTH-1:0] seq_a, seq_b;

    int checks = 0;
    int failures = 0;

    serial_compare_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .bit_a    (bit_a),
        .bit_b    (bit_b),
        .slice_lt (slice_lt),
        .slice_gt (slice_gt),
        .slice_eq (slice_eq),
        .busy     (busy),
        .done     (done),
        .a_lt_b   (a_lt_b),
        .a_gt_b   (a_gt_b),
        .a_eq_b   (a_eq_b),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Ideal comparator slice; a fault forces the contradictory lt=gt=1, eq=0.
    assign slice_eq = fault ? 1'b0 : (bit_a == bit_b);
    assign slice_lt = fault ? 1'b1 : (!bit_a && bit_b);
    assign slice_gt = fault ? 1'b1 : (bit_a && !bit_b);

    // Reference: bits examined = position of first difference from the MSB.
    function automatic int model_k(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        logic [WIDTH-1:0] diff;
        diff = av ^ bv;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (diff[i]) return WIDTH - i;
        return WIDTH;
    endfunction

    function automatic logic [3:0] model_res(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        if (av < bv) return 4'b1000;
        if (av > bv) return 4'b0100;
        return 4'b0010;
    endfunction

    // Runs one operation from IDLE; lat is the cycle (1 = first after the
    // accepting edge) in which done was seen, 0 if it never came.
    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input bit inj, output int lat, output logic [3:0] res,
                          output int busy_cnt, output bit held);
        logic [3:0] r0;
        @(posedge clk); #1;
        a = av; b = bv; start = 1'b1; fault = inj;
        @(posedge clk); #1;
        start = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        r0 = {a_lt_b, a_gt_b, a_eq_b, err};
        held = 1'b1; busy_cnt = 0; lat = 0; seq_a = '0; seq_b = '0;
        for (int n = 1; n <= WIDTH + 4; n++) begin
            if (done) begin lat = n; break; end
            if (busy) begin
                busy_cnt++;
                seq_a = {seq_a[WIDTH-2:0], bit_a};
                seq_b = {seq_b[WIDTH-2:0], bit_b};
            end
            if ({a_lt_b, a_gt_b, a_eq_b, err} !== r0) held = 1'b0;
            @(posedge clk); #1;
            fault = 1'b0;
        end
        res = {a_lt_b, a_gt_b, a_eq_b, err};
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy, done, a_lt_b, a_gt_b, a_eq_b, err, bit_a, bit_b} !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=00000000",
                     {busy, done, a_lt_b, a_gt_b, a_eq_b, err, bit_a, bit_b});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, a_lt_b, a_gt_b, a_eq_b, err} !== 6'h00) begin
            failures++;
            $display("FAIL post_reset_idle got=%b want=000000",
                     {busy, done, a_lt_b, a_gt_b, a_eq_b, err});
        end
    endtask

    task automatic test_equal_scan();
        int lat, bc; logic [3:0] res; bit held;
        run_op(8'hA5, 8'hA5, 1'b0, lat, res, bc, held);
        checks++;
        if (lat !== 9) begin failures++; $display("FAIL eq_latency got=%0d want=9", lat); end
        checks++;
        if (res !== 4'b0010) begin failures++; $display("FAIL eq_result got=%b want=0010", res); end
        checks++;
        if (bc !== 8) begin failures++; $display("FAIL eq_busy_cycles got=%0d want=8", bc); end
        checks++;
        if (seq_a !== 8'hA5 || seq_b !== 8'hA5) begin
            failures++;
            $display("FAIL eq_bit_sequence got=%h/%h want=a5/a5", seq_a, seq_b);
        end
    endtask

    task automatic test_msb_early();
        int lat, bc; logic [3:0] res; bit held;
        run_op(8'h80, 8'h7F, 1'b0, lat, res, bc, held);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL msb_latency got=%0d want=2", lat); end
        checks++;
        if (res !== 4'b0100) begin failures++; $display("FAIL msb_result got=%b want=0100", res); end
        checks++;
        if (bc !== 1) begin failures++; $display("FAIL msb_bits_examined got=%0d want=1", bc); end
    endtask

    task automatic test_lsb_diff();
        int lat, bc; logic [3:0] res; bit held;
        run_op(8'h12, 8'h13, 1'b0, lat, res, bc, held);
        checks++;
        if (lat !== 9 || res !== 4'b1000) begin
            failures++;
            $display("FAIL lsb_lt got lat=%0d res=%b want lat=9 res=1000", lat, res);
        end
        run_op(8'h13, 8'h12, 1'b0, lat, res, bc, held);
        checks++;
        if (lat !== 9 || res !== 4'b0100) begin
            failures++;
            $display("FAIL lsb_gt got lat=%0d res=%b want lat=9 res=0100", lat, res);
        end
        checks++;
        if (held !== 1'b1) begin failures++; $display("FAIL result_hold got=%0b want=1", held); end
    endtask

    task automatic test_start_ignored();
        int dones, first_done; bit busy_after;
        @(posedge clk); #1;
        a = 8'h00; b = 8'h00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0; first_done = 0; busy_after = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            if (done) begin
                dones++;
                if (first_done == 0) first_done = n;
            end
            if (first_done != 0 && n > first_done && busy) busy_after = 1'b1;
            start = (n == 3 || n == 9);
            a = (n == 3 || n == 9) ? 8'hFF : 8'h00;
            @(posedge clk); #1;
        end
        start = 1'b0; a = '0;
        checks++;
        if (dones !== 1 || first_done !== 9) begin
            failures++;
            $display("FAIL ignore_start_done got count=%0d at=%0d want count=1 at=9", dones, first_done);
        end
        checks++;
        if ({a_lt_b, a_gt_b, a_eq_b, err} !== 4'b0010) begin
            failures++;
            $display("FAIL ignore_start_result got=%b want=0010", {a_lt_b, a_gt_b, a_eq_b, err});
        end
        checks++;
        if (busy_after !== 1'b0) begin failures++; $display("FAIL ignore_start_restart got=1 want=0"); end
    endtask

    task automatic test_reset_mid();
        int lat, bc; logic [3:0] res; bit held, early_done;
        @(posedge clk); #1;
        a = 8'h01; b = 8'h00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; early_done = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            if (done) early_done = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (busy !== 1'b1 || early_done) begin
            failures++;
            $display("FAIL mid_reset_precond got busy=%b early_done=%b want 1/0", busy, early_done);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, a_lt_b, a_gt_b, a_eq_b, err, bit_a, bit_b} !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%b want=00000000",
                     {busy, done, a_lt_b, a_gt_b, a_eq_b, err, bit_a, bit_b});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_no_done got done=%b busy=%b want 0/0", done, busy);
        end
        run_op(8'h01, 8'h00, 1'b0, lat, res, bc, held);
        checks++;
        if (lat !== 9 || res !== 4'b0100) begin
            failures++;
            $display("FAIL after_reset_op got lat=%0d res=%b want lat=9 res=0100", lat, res);
        end
    endtask

    task automatic test_faulty_slice();
        int lat, bc; logic [3:0] res; bit held;
        run_op(8'h3C, 8'h3C, 1'b1, lat, res, bc, held);
        checks++;
        if (lat !== 2 || res !== 4'b0001) begin
            failures++;
            $display("FAIL fault_err got lat=%0d res=%b want lat=2 res=0001", lat, res);
        end
        run_op(8'h55, 8'h55, 1'b0, lat, res, bc, held);
        checks++;
        if (lat !== 9 || res !== 4'b0010) begin
            failures++;
            $display("FAIL fault_recover got lat=%0d res=%b want lat=9 res=0010", lat, res);
        end
    endtask

    task automatic test_back_to_back();
        int done_at[$]; int gap_bad;
        @(posedge clk); #1;
        a = 8'h80; b = 8'h7F; start = 1'b1;
        for (int n = 0; n < 13; n++) begin
            @(posedge clk); #1;
            if (done) done_at.push_back(n);
        end
        start = 1'b0;
        gap_bad = 0;
        for (int i = 1; i < done_at.size(); i++)
            if (done_at[i] - done_at[i-1] != 3) gap_bad++;
        checks++;
        if (done_at.size() < 4 || gap_bad != 0) begin
            failures++;
            $display("FAIL back_to_back got dones=%0d bad_gaps=%0d want >=4 dones every 3 cycles",
                     done_at.size(), gap_bad);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_random();
        int lat, bc, k; logic [3:0] res, want; bit held;
        logic [WIDTH-1:0] av, bv;
        for (int i = 0; i < 60; i++) begin
            av = WIDTH'($urandom);
            case ($urandom_range(0, 2))
                0: bv = av;
                1: bv = av ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
                default: bv = WIDTH'($urandom);
            endcase
            k = model_k(av, bv);
            want = model_res(av, bv);
            run_op(av, bv, 1'b0, lat, res, bc, held);
            checks++;
            if (lat !== k + 1 || res !== want || bc !== k) begin
                failures++;
                $display("FAIL random a=%h b=%h got lat=%0d busy=%0d res=%b want lat=%0d busy=%0d res=%b",
                         av, bv, lat, bc, res, k + 1, k, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_equal_scan();
        test_msb_early();
        test_lsb_diff();
        test_start_ignored();
        test_reset_mid();
        test_faulty_slice();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
